uart_tx_8n1: RTL and testbench

- Serial transmitter for the FPGA-to-Arduino link; counterpart of the existing UART receive path.
- Accepts one byte per valid/ready handshake and serialises it on a single line as 8N1: 1 start bit (low), 8 data bits LSB first, 1 stop bit (high).
- Bit timing comes from a cycle counter, using the same CLOCK_FREQ/BAUD_RATE derivation as the receiver, so the two ends interoperate with default parameters.

---
 rtl/uart_tx_8n1.sv | 122 ++++++++++++
 tb/tb_uart_tx_8n1.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_8n1.sv
// 8N1 serial transmitter: one byte per valid/ready handshake, shifted out LSB first
// with bit timing derived from CLOCK_FREQ/BAUD_RATE.
module uart_tx_8n1 #(
  parameter int BAUD_RATE  = 115200,
  parameter int CLOCK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       uart_tx
);

  localparam int          CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam logic [15:0] CNT_LAST     = 16'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_baud
      $fatal(1, "uart_tx_8n1: CLKS_PER_BIT=%0d must be within 2..65535", CLKS_PER_BIT);
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] clk_count_reg, clk_count_next;
  logic [2:0]  bit_index_reg, bit_index_next;
  logic [7:0]  shift_reg, shift_next;
  logic        tx_reg, tx_next;
  logic        done_reg, done_next;
  logic        bit_end;

  assign bit_end = (clk_count_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      clk_count_reg <= 16'd0;
      bit_index_reg <= 3'd0;
      shift_reg     <= 8'd0;
      tx_reg        <= 1'b1;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      clk_count_reg <= clk_count_next;
      bit_index_reg <= bit_index_next;
      shift_reg     <= shift_next;
      tx_reg        <= tx_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    clk_count_next = clk_count_reg;
    bit_index_next = bit_index_reg;
    shift_next     = shift_reg;
    done_next      = 1'b0;
    tx_next        = 1'b1;

    case (state_reg)
      IDLE: begin
        if (tx_start) begin
          shift_next     = tx_data;
          clk_count_next = 16'd0;
          bit_index_next = 3'd0;
          state_next     = START;
        end
      end
      START: begin
        if (bit_end) begin
          clk_count_next = 16'd0;
          state_next     = DATA;
        end else begin
          clk_count_next = clk_count_reg + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_count_next = 16'd0;
          bit_index_next = bit_index_reg + 3'd1;  // wraps to 0 after bit 7
          if (bit_index_reg == 3'd7) begin
            state_next = STOP;
          end
        end else begin
          clk_count_next = clk_count_reg + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          clk_count_next = 16'd0;
          state_next     = IDLE;
          done_next      = 1'b1;
        end else begin
          clk_count_next = clk_count_reg + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level is chosen from the upcoming state so it changes on the edge entering each bit.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[bit_index_next];
      default: tx_next = 1'b1;
    endcase
  end

  assign tx_ready = (state_reg == IDLE);
  assign tx_busy  = ~tx_ready;
  assign tx_done  = done_reg;
  assign uart_tx  = tx_reg;

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Bench for uart_tx_8n1: per-cycle frame model on a 4-cycles-per-bit instance, literal
// waveform pins for the directed cases, and a default-rate instance decoded by the bench.
module tb_uart_tx_8n1;

  localparam int CF  = 16;
  localparam int BR  = 4;
  localparam int N   = CF / BR;
  localparam int DN  = 50000000 / 115200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_busy, tx_done, uart_tx;

  logic       rst_d = 1'b1;
  logic       start_d = 1'b0;
  logic [7:0] data_d = 8'h00;
  logic       ready_d, busy_d, done_d, uart_tx_d;

  always #5 clk = ~clk;

  uart_tx_8n1 #(.BAUD_RATE(BR), .CLOCK_FREQ(CF)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .uart_tx(uart_tx)
  );

  uart_tx_8n1 dut_dflt (
    .clk(clk), .rst(rst_d), .tx_data(data_d), .tx_start(start_d),
    .tx_ready(ready_d), .tx_busy(busy_d), .tx_done(done_d), .uart_tx(uart_tx_d)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Frame model: a frame accepted at edge s occupies cycles s..s+10N-1 (bit = k/N),
  // and the cycle s+10N is the idle tx_done cycle.
  int         cyc = 0;
  int         s_cyc = 0;
  int         mk;
  bit         active = 1'b0;
  bit         mvalid = 1'b0;
  logic [7:0] mbyte = 8'h00;
  logic       e_tx = 1'b1, e_ready = 1'b1, e_busy = 1'b0, e_done = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      active = 1'b0;
    end else if ((!active || (cyc - 1 - s_cyc) >= 10 * N) && tx_start) begin
      s_cyc  = cyc;
      mbyte  = tx_data;
      active = 1'b1;
      $display("tx accept byte 0x%02h at cycle %0d", tx_data, cyc);
    end
    mk = cyc - s_cyc;
    if (active && mk < 10 * N) begin
      e_busy  = 1'b1;
      e_ready = 1'b0;
      e_done  = 1'b0;
      if (mk < N)          e_tx = 1'b0;
      else if (mk < 9 * N) e_tx = mbyte[mk / N - 1];
      else                 e_tx = 1'b1;
    end else begin
      e_busy  = 1'b0;
      e_ready = 1'b1;
      e_tx    = 1'b1;
      e_done  = active && (mk == 10 * N);
    end
    mvalid = 1'b1;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("uart_tx", uart_tx, e_tx);
      chk("tx_ready", tx_ready, e_ready);
      chk("tx_busy", tx_busy, e_busy);
      chk("tx_done", tx_done, e_done);
    end
  end

  logic rec_tx[0:99];
  logic rec_busy[0:99];
  logic rec_done[0:99];
  logic rec_ready[0:99];

  bit pat_a3[10] = '{0, 1, 1, 0, 0, 0, 1, 0, 1, 1};
  bit pat_55[10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
  bit pat_3c[10] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 1};

  task automatic sample(input int k);
    rec_tx[k]    = uart_tx;
    rec_busy[k]  = tx_busy;
    rec_done[k]  = tx_done;
    rec_ready[k] = tx_ready;
  endtask

  task automatic chk_pat(input string nm, input bit p[10]);
    for (int b = 0; b < 10; b++) begin
      chk($sformatf("%s_bit%0d_first", nm, b), rec_tx[b * N], p[b]);
      chk($sformatf("%s_bit%0d_last", nm, b), rec_tx[b * N + N - 1], p[b]);
    end
  endtask

  initial begin
    int cnt;
    int done_a, done_b;
    logic [7:0] rx;
    logic [7:0] lb_bytes [4];
    lb_bytes = '{8'h00, 8'h7E, 8'h81, 8'hFF};

    // Reset held with tx_start asserted: nothing may start
    tx_start = 1'b1;
    tx_data  = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold_tx", uart_tx, 1'b1);
      chk("rst_hold_busy", tx_busy, 1'b0);
      chk("rst_hold_done", tx_done, 1'b0);
    end

    // Frame waveform, 0xA3
    tx_data = 8'hA3;
    rst     = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      sample(k);
      if (k == 0) tx_start = 1'b0;
    end
    chk_pat("a3", pat_a3);
    cnt = 0;
    for (int k = 0; k < 40; k++) cnt += int'(rec_busy[k]);
    chk("a3_busy_cycles", cnt, 40);
    cnt = 0;
    for (int k = 0; k < 40; k++) cnt += int'(rec_done[k]);
    chk("a3_no_early_done", cnt, 0);
    chk("a3_done_cycle41", rec_done[40], 1'b1);
    chk("a3_ready_cycle41", rec_ready[40], 1'b1);

    // Busy ignore: 0x55 with a 0xFF request mid-frame
    @(negedge clk);
    tx_data  = 8'h55;
    tx_start = 1'b1;
    for (int k = 0; k < 52; k++) begin
      @(negedge clk);
      sample(k);
      if (k == 0)  tx_start = 1'b0;
      if (k == 10) begin tx_data = 8'hFF; tx_start = 1'b1; end
      if (k == 13) tx_start = 1'b0;
    end
    chk_pat("55", pat_55);
    cnt = 0;
    for (int k = 40; k < 52; k++) cnt += int'(rec_tx[k] == 1'b1 && rec_busy[k] == 1'b0);
    chk("55_idle_after", cnt, 12);

    // Back-to-back: 0x00 then 0xFF, tx_start held across tx_done
    @(negedge clk);
    tx_data  = 8'h00;
    tx_start = 1'b1;
    for (int k = 0; k < 90; k++) begin
      @(negedge clk);
      sample(k);
      if (k == 5)  tx_data = 8'hFF;
      if (k == 41) tx_start = 1'b0;
    end
    done_a = -1;
    done_b = -1;
    cnt = 0;
    for (int k = 0; k < 90; k++) begin
      if (rec_done[k]) begin
        cnt++;
        if (done_a < 0) done_a = k; else done_b = k;
      end
    end
    chk("b2b_done_count", cnt, 2);
    chk("b2b_done_spacing", done_b - done_a, 41);
    chk("b2b_gap_high", rec_tx[40], 1'b1);
    chk("b2b_start2_low", rec_tx[41], 1'b0);
    chk("b2b_ff_bit0", rec_tx[45], 1'b1);
    chk("b2b_00_bit7", rec_tx[35], 1'b0);

    // Reset mid-frame, then a fresh 0x3C
    @(negedge clk);
    tx_data  = 8'h3C;
    tx_start = 1'b1;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (k == 0)  tx_start = 1'b0;
      if (k == 17) rst = 1'b1;
    end
    @(negedge clk);
    chk("midrst_tx", uart_tx, 1'b1);
    chk("midrst_ready", tx_ready, 1'b1);
    chk("midrst_done", tx_done, 1'b0);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      cnt += int'(tx_done);
    end
    chk("midrst_no_done", cnt, 0);
    tx_start = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      sample(k);
      if (k == 0) tx_start = 1'b0;
    end
    chk_pat("3c", pat_3c);
    chk("3c_done", rec_done[40], 1'b1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 149) == 0);
      tx_start = ($urandom_range(0, 3) == 0);
      tx_data  = 8'($urandom);
    end
    @(negedge clk);
    rst      = 1'b0;
    tx_start = 1'b0;
    repeat (50) @(negedge clk);

    // Default-rate instance: line timing against 434 cycles per bit, bench-side decode
    rst_d = 1'b0;
    repeat (2) @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      data_d  = lb_bytes[j];
      start_d = 1'b1;
      cnt = 0;
      rx  = 8'h00;
      for (int k = 0; k < 10 * DN; k++) begin
        logic expb;
        int   bi;
        @(negedge clk);
        if (k == 0) start_d = 1'b0;
        bi = k / DN;
        if (bi == 0)      expb = 1'b0;
        else if (bi <= 8) expb = lb_bytes[j][bi - 1];
        else              expb = 1'b1;
        if (uart_tx_d !== expb) cnt++;
        if (bi >= 1 && bi <= 8 && (k % DN) == DN / 2) rx[bi - 1] = uart_tx_d;
      end
      @(negedge clk);
      chk($sformatf("dflt_line_%02h", lb_bytes[j]), cnt, 0);
      chk($sformatf("dflt_decode_%02h", lb_bytes[j]), rx, lb_bytes[j]);
      chk($sformatf("dflt_done_%02h", lb_bytes[j]), done_d, 1'b1);
      $display("default-rate frame 0x%02h decoded as 0x%02h", lb_bytes[j], rx);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
